// File: rtl/rr_mux_arbiter3.sv
// rr_mux_arbiter3
// Round-robin arbiter that owns the select/enable of one shared 3-input mux.
// One requester holds the grant at a time. The grant is kept until the owner
// pulses done or drops its request. With ARB_TIMEOUT_EN defined, the grant is
// also released after MAX_HOLD consecutive cycles without a release.
//
// Ports:
//   clk      rising-edge clock
//   rstn     synchronous active-low reset (has priority over en)
//   en       global enable; when low every register holds
//   req[2:0] level requests, held until served
//   done     one-cycle pulse: current owner finished its transaction
//   gnt[2:0] registered one-hot grant
//   sel[1:0] registered mux select = owner index (00/01/10)
//   mux_en   registered mux enable, equal to |gnt
//   busy     state == GRANT
//   timeout  one-cycle pulse after a forced release (0 without ARB_TIMEOUT_EN)
//
// Optional feature macro: ARB_TIMEOUT_EN
module rr_mux_arbiter3 #(
   parameter int MAX_HOLD  = 16,
   parameter int CNT_WIDTH = 5
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [2:0] req,
   input  logic       done,
   output logic [2:0] gnt,
   output logic [1:0] sel,
   output logic       mux_en,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nx;
   logic [2:0] gnt_nx;
   logic [1:0] sel_nx, ptr, ptr_nx, win;
   logic       mux_en_nx, timeout_nx;
   logic       owner_req, rel, force_rel;

   if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_WIDTH)) begin : g_bad_max_hold
      $error("rr_mux_arbiter3: MAX_HOLD out of range for CNT_WIDTH");
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_SAT  = '1;
   logic [CNT_WIDTH-1:0] hold_cnt, hold_nx;
`endif

   // First asserted request in (ptr+1, ptr+2, ptr) order; the last owner
   // only wins when nobody else is asking.
   function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
      logic [1:0] c0, c1;
      c0 = (p == 2'd2) ? 2'd0 : p + 2'd1;
      c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
      if (r[c0])      return c0;
      else if (r[c1]) return c1;
      else            return p;
   endfunction

   assign win       = rr_pick(ptr, req);
   // gnt is one-hot on the owner while in GRANT, so it masks the owner's req.
   assign owner_req = |(req & gnt);
   assign busy      = (state == GRANT);

`ifdef ARB_TIMEOUT_EN
   // Forced release only when no natural release happens in the same cycle.
   assign force_rel = (state == GRANT) && (hold_cnt == HOLD_LAST) && !done && owner_req;
`else
   assign force_rel = 1'b0;
`endif

   always_comb begin
      state_nx   = state;
      gnt_nx     = gnt;
      sel_nx     = sel;
      ptr_nx     = ptr;
      mux_en_nx  = mux_en;
      timeout_nx = 1'b0;
      rel        = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_nx    = hold_cnt;
`endif
      case (state)
         IDLE: begin
            if (|req) begin
               state_nx  = GRANT;
               gnt_nx    = 3'b001 << win;
               sel_nx    = win;
               ptr_nx    = win;
               mux_en_nx = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_nx   = '0;
`endif
            end
         end
         GRANT: begin
            rel = done | ~owner_req | force_rel;
            if (rel) begin
               timeout_nx = force_rel;
`ifdef ARB_TIMEOUT_EN
               hold_nx    = '0;
`endif
               if (|req) begin
                  // Same-edge regrant: no idle bubble between owners.
                  gnt_nx = 3'b001 << win;
                  sel_nx = win;
                  ptr_nx = win;
               end else begin
                  // sel deliberately keeps the last owner.
                  state_nx  = IDLE;
                  gnt_nx    = 3'b000;
                  mux_en_nx = 1'b0;
               end
            end else begin
`ifdef ARB_TIMEOUT_EN
               if (hold_cnt != HOLD_SAT) hold_nx = hold_cnt + 1'b1;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         gnt      <= 3'b000;
         sel      <= 2'b00;
         ptr      <= 2'd2;
         mux_en   <= 1'b0;
         timeout  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= '0;
`endif
      end else if (en) begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         sel      <= sel_nx;
         ptr      <= ptr_nx;
         mux_en   <= mux_en_nx;
         timeout  <= timeout_nx;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= hold_nx;
`endif
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter3.sv
// Self-checking bench for rr_mux_arbiter3. A behavioural model predicts the
// outputs for every driven cycle; predictions are queued at drive time and
// compared after the clock edge. Directed constant checks cover the main
// scenarios. Built with or without ARB_TIMEOUT_EN.
module tb_rr_mux_arbiter3;

   localparam int MAX_HOLD  = 4;
   localparam int CNT_WIDTH = 5;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk, rstn, en, done;
   logic [2:0] req, gnt;
   logic [1:0] sel;
   logic       mux_en, busy, timeout;

   rr_mux_arbiter3 #(.MAX_HOLD(MAX_HOLD), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .rstn(rstn), .en(en), .req(req), .done(done),
      .gnt(gnt), .sel(sel), .mux_en(mux_en), .busy(busy), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] gnt;
      logic [1:0] sel;
      logic       mux_en;
      logic       busy;
      logic       timeout;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // model state
   int m_busy = 0, m_ptr = 2, m_gnt = 0, m_sel = 0, m_hold = 0, m_to = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int pick(input int p, input logic [2:0] r);
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (p + k) % 3;
         if (r[c]) return c;
      end
      return p;
   endfunction

   task automatic model_grant(input int w);
      m_gnt  = 1 << w;
      m_sel  = w;
      m_ptr  = w;
      m_busy = 1;
      m_hold = 0;
   endtask

   task automatic model_step(input logic r_n, input logic e, input logic [2:0] r, input logic d);
      bit own_hi, forced;
      if (!r_n) begin
         m_busy = 0; m_gnt = 0; m_sel = 0; m_ptr = 2; m_hold = 0; m_to = 0;
      end else if (e) begin
         m_to = 0;
         if (m_busy == 0) begin
            if (r != 3'b000) model_grant(pick(m_ptr, r));
         end else begin
            own_hi = r[m_ptr];
            forced = TO_EN && (m_hold == MAX_HOLD - 1) && !d && own_hi;
            if (d || !own_hi || forced) begin
               m_to = forced;
               if (r != 3'b000) model_grant(pick(m_ptr, r));
               else begin
                  m_busy = 0; m_gnt = 0; m_hold = 0;
               end
            end else if (TO_EN && m_hold < (1 << CNT_WIDTH) - 1) begin
               m_hold++;
            end
         end
      end
   endtask

   task automatic step(input logic r_n, input logic e, input logic [2:0] r, input logic d);
      exp_t x;
      @(negedge clk);
      rstn = r_n; en = e; req = r; done = d;
      model_step(r_n, e, r, d);
      x.gnt     = 3'(m_gnt);
      x.sel     = 2'(m_sel);
      x.mux_en  = (m_gnt != 0);
      x.busy    = (m_busy != 0);
      x.timeout = (m_to != 0);
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("gnt",     32'(gnt),     32'(x.gnt));
      chk("sel",     32'(sel),     32'(x.sel));
      chk("mux_en",  32'(mux_en),  32'(x.mux_en));
      chk("busy",    32'(busy),    32'(x.busy));
      chk("timeout", 32'(timeout), 32'(x.timeout));
      chk("onehot",  32'($onehot0(gnt)), 32'd1);
      chk("sel_ok",  32'(sel != 2'b11), 32'd1);
   endtask

   initial begin
      rstn = 1'b0; en = 1'b1; req = 3'b000; done = 1'b0;

      // 1. reset with all requests high
      step(0, 1, 3'b111, 0);
      step(0, 1, 3'b111, 0);
      chk("t1_rst_gnt",  32'(gnt), 32'b000);
      chk("t1_rst_busy", 32'(busy), 32'd0);
      step(1, 1, 3'b111, 0);
      chk("t1_first_gnt", 32'(gnt), 32'b001);

      // 2. fairness with done every 3rd cycle
      for (int i = 0; i < 9; i++) begin
         step(1, 1, 3'b111, (i % 3) == 2);
         chk("t2_nobubble", 32'(gnt != 3'b000), 32'd1);
         if (i == 2) chk("t2_gnt_b", 32'(gnt), 32'b010);
         if (i == 5) chk("t2_gnt_c", 32'(gnt), 32'b100);
         if (i == 8) chk("t2_gnt_d", 32'(gnt), 32'b001);
      end

      // 3. sole requester self-regrant, then drop
      step(1, 1, 3'b010, 0);
      chk("t3_gnt", 32'(gnt), 32'b010);
      step(1, 1, 3'b010, 1);
      chk("t3_regrant", 32'(gnt), 32'b010);
      chk("t3_mux_en", 32'(mux_en), 32'd1);
      step(1, 1, 3'b000, 0);
      chk("t3_idle_gnt", 32'(gnt), 32'b000);
      chk("t3_sel_hold", 32'(sel), 32'b01);

      // 4. drop without done, then new request
      step(1, 1, 3'b001, 0);
      step(1, 1, 3'b001, 0);
      step(1, 1, 3'b000, 0);
      chk("t4_idle", 32'(busy), 32'd0);
      step(1, 1, 3'b100, 0);
      chk("t4_gnt", 32'(gnt), 32'b100);

      // 5. enable freeze while owner 1
      step(1, 1, 3'b010, 0);
      chk("t5_owner1", 32'(gnt), 32'b010);
      for (int i = 0; i < 3; i++) step(1, 0, 3'b101, 1);
      chk("t5_frz_gnt", 32'(gnt), 32'b010);
      chk("t5_frz_sel", 32'(sel), 32'b01);
      step(1, 1, 3'b111, 0);
      chk("t5_resume", 32'(gnt), 32'b010);

      // 6. hold / timeout behaviour
      step(1, 1, 3'b000, 0);
      step(1, 1, 3'b011, 0);
      chk("t6_gnt0", 32'(gnt), 32'b001);
      for (int k = 1; k <= 25; k++) begin
         step(1, 1, 3'b011, 0);
         if (TO_EN) begin
            if (k < 4)  chk("t6_hold", 32'(gnt), 32'b001);
            if (k == 4) chk("t6_forced_gnt", 32'(gnt), 32'b010);
            if (k == 4) chk("t6_to_pulse", 32'(timeout), 32'd1);
            if (k == 5) chk("t6_to_clear", 32'(timeout), 32'd0);
         end else begin
            chk("t6_held", 32'(gnt), 32'b001);
            chk("t6_no_to", 32'(timeout), 32'd0);
         end
      end

      // random traffic checked by the model
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
